// File: rtl/rfid_sensor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rfid_sensor_pkg                                                    |
// | Shared types and constants for the sensor ADC sequencer.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rfid_sensor_pkg;

   localparam int SENSOR_CNT = 3;
   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] SENS_TEMP  = 2'd0;
   localparam logic [1:0] SENS_LIGHT = 2'd1;
   localparam logic [1:0] SENS_PRESS = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_START    = 3'd2,
      ST_WAIT_EOC = 3'd3,
      ST_SHIFT    = 3'd4,
      ST_EMIT     = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_serial_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_serial_rx                                                      |
// | Serial ADC clock generator and MSB-first shift register.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module adc_serial_rx #(
   parameter int DATA_W    = 8,
   parameter int SCLK_HALF = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              sdo,
   output logic              sclk,
   output logic [DATA_W-1:0] data,
   output logic              done
);

   localparam int                DIV_W     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_HALF - 1);
   localparam int                RISE_W    = $clog2(DATA_W + 1);
   localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(DATA_W);

   logic              r_active;
   logic [DIV_W-1:0]  r_div;
   logic [RISE_W-1:0] r_rises;
   logic              w_tick;

   assign w_tick = r_active && (r_div >= DIV_LAST);
   // Final falling toggle after the last rising edge ends the transfer.
   assign done   = w_tick && sclk && (r_rises >= RISE_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_active <= 1'b0;
         r_div    <= '0;
         r_rises  <= '0;
         sclk     <= 1'b0;
         data     <= '0;
      end else if (go) begin
         r_active <= 1'b1;
         r_div    <= '0;
         r_rises  <= '0;
         sclk     <= 1'b0;
      end else if (w_tick) begin
         r_div <= '0;
         sclk  <= ~sclk;
         if (!sclk) begin
            data    <= {data[DATA_W-2:0], sdo};
            r_rises <= r_rises + RISE_W'(1);
         end
         if (done)
            r_active <= 1'b0;
      end else if (r_active) begin
         r_div <= r_div + DIV_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/sensor_adc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sensor_adc_seq                                                     |
// | Converts each flagged sensor on the serial ADC, one tagged word    |
// | per sensor, then a seq_done pulse.                                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sensor_adc_seq
   import rfid_sensor_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SCLK_HALF   = 2,
   parameter int SETTLE_CYC  = 16,
   parameter int EOC_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_req,
   input  logic [SENSOR_CNT-1:0] senscode,
   input  logic                  adc_eoc,
   input  logic                  adc_sdo,
   output logic [1:0]            adc_mux,
   output logic                  adc_start,
   output logic                  adc_cs_n,
   output logic                  adc_sclk,
   output logic [DATA_W-1:0]     ADC_data,
   output logic                  ADC_data_ready,
   output logic [1:0]            adc_sensor_id,
   output logic                  adc_timeout,
   output logic                  busy,
   output logic                  seq_done
);

   localparam int SHIFT_CYC = 2 * SCLK_HALF * DATA_W;
   localparam int CNT_MAX   = (SETTLE_CYC > EOC_TIMEOUT)
                              ? ((SETTLE_CYC > SHIFT_CYC) ? SETTLE_CYC : SHIFT_CYC)
                              : ((EOC_TIMEOUT > SHIFT_CYC) ? EOC_TIMEOUT : SHIFT_CYC);
   localparam int               CNT_W       = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] EOC_LAST    = CNT_W'(EOC_TIMEOUT - 1);

   state_t                r_state;
   logic [SENSOR_CNT-1:0] r_pend;
   logic [SENSOR_CNT-1:0] w_pend_clr;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_timeout_flag;
   logic                  w_rx_go;
   logic                  w_rx_done;
   logic [DATA_W-1:0]     w_rx_data;

   function automatic logic [1:0] lowest_set(input logic [SENSOR_CNT-1:0] mask);
      logic [1:0] idx;
      idx = SENS_TEMP;
      if (mask[2]) idx = SENS_PRESS;
      if (mask[1]) idx = SENS_LIGHT;
      if (mask[0]) idx = SENS_TEMP;
      return idx;
   endfunction

   assign w_pend_clr = r_pend & ~(SENSOR_CNT'(1) << adc_mux);
   assign w_rx_go    = (r_state == ST_WAIT_EOC) && adc_eoc;

   adc_serial_rx #(
      .DATA_W    (DATA_W),
      .SCLK_HALF (SCLK_HALF)
   ) u_rx (
      .clk   (clk),
      .reset (reset),
      .go    (w_rx_go),
      .sdo   (adc_sdo),
      .sclk  (adc_sclk),
      .data  (w_rx_data),
      .done  (w_rx_done)
   );

   // adc_mux is loaded on entry to SELECT so the full settle window sees it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_pend         <= '0;
         r_cnt          <= '0;
         r_timeout_flag <= 1'b0;
         adc_mux        <= 2'd0;
         adc_start      <= 1'b0;
         adc_cs_n       <= 1'b1;
         ADC_data       <= '0;
         ADC_data_ready <= 1'b0;
         adc_sensor_id  <= 2'd0;
         adc_timeout    <= 1'b0;
         busy           <= 1'b0;
         seq_done       <= 1'b0;
      end else begin
         adc_start      <= 1'b0;
         ADC_data_ready <= 1'b0;
         adc_timeout    <= 1'b0;
         seq_done       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sample_req) begin
                  r_pend  <= senscode;
                  busy    <= 1'b1;
                  r_cnt   <= '0;
                  adc_mux <= lowest_set(senscode);
                  if (senscode == '0)
                     r_state <= ST_DONE;
                  else
                     r_state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (r_cnt >= SETTLE_LAST) begin
                  r_cnt     <= '0;
                  adc_start <= 1'b1;
                  adc_cs_n  <= 1'b0;
                  r_state   <= ST_START;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_START: begin
               r_cnt          <= '0;
               r_timeout_flag <= 1'b0;
               r_state        <= ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
               if (adc_eoc) begin
                  r_state <= ST_SHIFT;
               end else if (r_cnt >= EOC_LAST) begin
                  r_timeout_flag <= 1'b1;
                  r_state        <= ST_EMIT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (w_rx_done)
                  r_state <= ST_EMIT;
            end
            ST_EMIT: begin
               ADC_data       <= r_timeout_flag ? '0 : w_rx_data;
               ADC_data_ready <= 1'b1;
               adc_sensor_id  <= adc_mux;
               adc_timeout    <= r_timeout_flag;
               adc_cs_n       <= 1'b1;
               r_pend         <= w_pend_clr;
               r_cnt          <= '0;
               if (w_pend_clr != '0) begin
                  adc_mux <= lowest_set(w_pend_clr);
                  r_state <= ST_SELECT;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               seq_done <= 1'b1;
               busy     <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sensor_adc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sensor_adc_seq                                                  |
// | Directed bench with a behavioural serial ADC; two DUT instances.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sensor_adc_seq;

   localparam int EOC_DLY = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, sample_req, sel2, eoc_en, log_clr;
   logic [2:0] senscode;
   logic       adc_eoc, adc_sdo;
   logic       req1, req2;
   logic [7:0] tx_word [4];

   assign req1 = sample_req & ~sel2;
   assign req2 = sample_req & sel2;

   logic [1:0] d1_mux, d2_mux, d1_id, d2_id, m_mux, m_id;
   logic       d1_start, d1_cs_n, d1_sclk, d1_rdy, d1_to, d1_busy, d1_done;
   logic       d2_start, d2_cs_n, d2_sclk, d2_rdy, d2_to, d2_busy, d2_done;
   logic       m_start, m_cs_n, m_sclk, m_rdy, m_to, m_busy, m_done;
   logic [7:0] d1_data, d2_data, m_data;

   sensor_adc_seq u_dut (
      .clk(clk), .reset(reset), .sample_req(req1), .senscode(senscode),
      .adc_eoc(adc_eoc), .adc_sdo(adc_sdo), .adc_mux(d1_mux), .adc_start(d1_start),
      .adc_cs_n(d1_cs_n), .adc_sclk(d1_sclk), .ADC_data(d1_data),
      .ADC_data_ready(d1_rdy), .adc_sensor_id(d1_id), .adc_timeout(d1_to),
      .busy(d1_busy), .seq_done(d1_done)
   );

   sensor_adc_seq #(.SCLK_HALF(1)) u_dut_fast (
      .clk(clk), .reset(reset), .sample_req(req2), .senscode(senscode),
      .adc_eoc(adc_eoc), .adc_sdo(adc_sdo), .adc_mux(d2_mux), .adc_start(d2_start),
      .adc_cs_n(d2_cs_n), .adc_sclk(d2_sclk), .ADC_data(d2_data),
      .ADC_data_ready(d2_rdy), .adc_sensor_id(d2_id), .adc_timeout(d2_to),
      .busy(d2_busy), .seq_done(d2_done)
   );

   assign m_mux   = sel2 ? d2_mux   : d1_mux;
   assign m_id    = sel2 ? d2_id    : d1_id;
   assign m_start = sel2 ? d2_start : d1_start;
   assign m_cs_n  = sel2 ? d2_cs_n  : d1_cs_n;
   assign m_sclk  = sel2 ? d2_sclk  : d1_sclk;
   assign m_rdy   = sel2 ? d2_rdy   : d1_rdy;
   assign m_to    = sel2 ? d2_to    : d1_to;
   assign m_busy  = sel2 ? d2_busy  : d1_busy;
   assign m_done  = sel2 ? d2_done  : d1_done;
   assign m_data  = sel2 ? d2_data  : d1_data;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int req_cyc;
   int done_cnt, done_cyc, busy_cnt, busy_rise_cyc;
   int rdy_cyc_q[$], eoc_cyc_q[$], rise_cyc_q[$];
   logic [1:0] id_q[$], mux_q[$];
   logic [7:0] data_q[$];
   logic       to_q[$];
   logic       mon_prev_sclk = 1'b0, mon_prev_busy = 1'b0, sdo_prev_sclk = 1'b0;
   int         eoc_cnt = 0, bit_ptr = 7;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log, sampled mid-cycle.
   always @(negedge clk) begin
      if (log_clr) begin
         rdy_cyc_q.delete(); rise_cyc_q.delete(); id_q.delete(); mux_q.delete();
         data_q.delete(); to_q.delete();
         done_cnt = 0; done_cyc = 0; busy_cnt = 0; busy_rise_cyc = 0;
      end
      if (m_rdy) begin
         id_q.push_back(m_id); data_q.push_back(m_data);
         to_q.push_back(m_to); rdy_cyc_q.push_back(cyc);
      end
      if (m_done) begin done_cnt++; done_cyc = cyc; end
      if (m_start) mux_q.push_back(m_mux);
      if (m_sclk && !mon_prev_sclk) rise_cyc_q.push_back(cyc);
      if (m_busy) busy_cnt++;
      if (m_busy && !mon_prev_busy) busy_rise_cyc = cyc;
      mon_prev_sclk = m_sclk;
      mon_prev_busy = m_busy;
   end

   // Behavioural ADC: end-of-conversion a fixed delay after start.
   always @(negedge clk) begin
      if (log_clr) eoc_cyc_q.delete();
      if (m_start) eoc_cnt = 1;
      else if (m_cs_n) eoc_cnt = 0;
      else if (eoc_cnt != 0 && eoc_cnt < EOC_DLY) eoc_cnt++;
      if (eoc_en && eoc_cnt >= EOC_DLY && adc_eoc !== 1'b1) eoc_cyc_q.push_back(cyc);
      adc_eoc = eoc_en && (eoc_cnt >= EOC_DLY);
   end

   // Behavioural ADC: next bit presented after each sclk rise.
   always @(negedge clk) begin
      if (m_cs_n) bit_ptr = 7;
      else if (m_sclk && !sdo_prev_sclk && bit_ptr != 0) bit_ptr--;
      sdo_prev_sclk = m_sclk;
      adc_sdo = tx_word[m_mux][bit_ptr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      log_clr = 1'b1;
      @(negedge clk); #1;
      log_clr = 1'b0;
   endtask

   task automatic run_seq(input logic [2:0] code, input bit disturb);
      clear_log();
      senscode = code; sample_req = 1'b1; req_cyc = cyc;
      @(negedge clk); #1;
      sample_req = 1'b0;
      for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
         @(negedge clk); #1;
         if (disturb && i == 20) begin
            sample_req = 1'b1; senscode = 3'b110;
         end else begin
            sample_req = 1'b0;
         end
      end
      check("seq_done_seen", 32'(done_cnt != 0), 32'd1);
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; sample_req = 1'b0; senscode = 3'b000; sel2 = 1'b0;
      eoc_en = 1'b1; log_clr = 1'b0;
      tx_word[0] = 8'hA5; tx_word[1] = 8'h00; tx_word[2] = 8'h3C; tx_word[3] = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs",
            {13'd0, d1_mux, d1_start, d1_cs_n, d1_sclk, d1_data, d1_rdy, d1_id, d1_to, d1_busy, d1_done},
            {13'd0, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
      reset = 1'b1;
      @(negedge clk); #1;

      // Sensors 0 and 2.
      run_seq(3'b101, 1'b0);
      check("t1_ready_count", id_q.size(), 2);
      if (id_q.size() == 2) begin
         check("t1_id0", id_q[0], 0);
         check("t1_data0", data_q[0], 8'hA5);
         check("t1_id1", id_q[1], 2);
         check("t1_data1", data_q[1], 8'h3C);
         check("t1_timeout", {to_q[0], to_q[1]}, 0);
      end
      check("t1_done_count", done_cnt, 1);
      check("t1_mux_seq", {mux_q.size() == 2 ? mux_q[0] : 2'd3, mux_q.size() == 2 ? mux_q[1] : 2'd3}, {2'd0, 2'd2});
      check("t1_eoc_to_ready", (rdy_cyc_q.size() > 0 && eoc_cyc_q.size() > 0) ? rdy_cyc_q[0] - eoc_cyc_q[0] : -1, 34);
      check("t1_busy_after", d1_busy, 0);

      // Empty mask.
      run_seq(3'b000, 1'b0);
      check("t2_ready_count", id_q.size(), 0);
      check("t2_done_latency", done_cyc - req_cyc, 2);
      check("t2_busy_cycles", busy_cnt, 1);

      // EOC never arrives.
      eoc_en = 1'b0;
      run_seq(3'b010, 1'b0);
      eoc_en = 1'b1;
      check("t3_ready_count", id_q.size(), 1);
      if (id_q.size() == 1) begin
         check("t3_id", id_q[0], 1);
         check("t3_data", data_q[0], 8'h00);
         check("t3_timeout", to_q[0], 1);
         check("t3_latency", rdy_cyc_q[0] - busy_rise_cyc, 273);
      end

      // Request and mask change while busy are ignored.
      tx_word[0] = 8'h5A;
      run_seq(3'b001, 1'b1);
      senscode = 3'b000;
      check("t4_ready_count", id_q.size(), 1);
      if (id_q.size() == 1) begin
         check("t4_id", id_q[0], 0);
         check("t4_data", data_q[0], 8'h5A);
      end
      check("t4_done_count", done_cnt, 1);

      // Asynchronous reset during the serial transfer.
      clear_log();
      senscode = 3'b001; sample_req = 1'b1;
      @(negedge clk); #1;
      sample_req = 1'b0;
      for (int i = 0; i < 200 && !d1_sclk; i++) @(negedge clk);
      check("t5_reached_shift", d1_sclk, 1);
      #2 reset = 1'b0;
      #1;
      check("t5_cs_n", d1_cs_n, 1);
      check("t5_sclk", d1_sclk, 0);
      check("t5_busy", d1_busy, 0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("t5_no_ready", id_q.size(), 0);
      check("t5_no_done", done_cnt, 0);
      tx_word[0] = 8'hA5;
      run_seq(3'b101, 1'b0);
      check("t5_rerun_count", id_q.size(), 2);
      if (id_q.size() == 2) begin
         check("t5_rerun_data0", data_q[0], 8'hA5);
         check("t5_rerun_data1", data_q[1], 8'h3C);
      end

      // Fast serial clock instance.
      sel2 = 1'b1;
      tx_word[0] = 8'hFF;
      run_seq(3'b001, 1'b0);
      check("t6_data", data_q.size() == 1 ? data_q[0] : 8'h00, 8'hFF);
      check("t6_sclk_rises", rise_cyc_q.size(), 8);
      check("t6_sclk_span", rise_cyc_q.size() == 8 ? rise_cyc_q[7] - rise_cyc_q[0] : -1, 14);
      check("t6_eoc_to_ready", (rdy_cyc_q.size() > 0 && eoc_cyc_q.size() > 0) ? rdy_cyc_q[0] - eoc_cyc_q[0] : -1, 18);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
